// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: saturates a signed control word to the legal pulse window
// and emits one glitch-free PWM frame per period plus a per-frame sample tick.
module servo_pwm_gen #(
  parameter int unsigned Magnitud      = 17,
  parameter int unsigned Decimal       = 0,
  parameter int unsigned N             = Magnitud + Decimal + 1,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned PERIOD_CYCLES = 1000000,
  parameter int unsigned MIN_PULSE     = 50000,
  parameter int unsigned MAX_PULSE     = 100000,
  parameter int unsigned CENTER        = 75000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic         load,
  input  logic [N-1:0] control,
  output logic         pwm,
  output logic         period_tick,
  output logic         sat,
  output logic         active
);

  // Sum width covers both the full control range and the pulse range plus headroom.
  localparam int unsigned SUM_W = ((N > CNT_W) ? N : CNT_W) + 2;

  localparam logic signed [SUM_W-1:0] CENTER_S = SUM_W'(CENTER);
  localparam logic signed [SUM_W-1:0] MIN_S    = SUM_W'(MIN_PULSE);
  localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0]        MIN_C    = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0]        MAX_C    = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0]        CENTER_C = CNT_W'(CENTER);
  localparam logic [CNT_W-1:0]        LAST_C   = CNT_W'(PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   pending_q;
  logic [CNT_W-1:0]   cmp_q;
  logic               pwm_q;
  logic               tick_q;
  logic               sat_q;
  logic               active_q;

  logic signed [N-1:0]     ctrl_s;
  logic signed [N-1:0]     u_s;
  logic signed [SUM_W-1:0] u_ext;
  logic signed [SUM_W-1:0] sum_s;
  logic [CNT_W-1:0]        pending_d;
  logic                    sat_d;
  logic                    at_last;

  // Control word to saturated compare value.
  always_comb begin
    ctrl_s    = control;
    u_s       = ctrl_s >>> Decimal;
    u_ext     = SUM_W'(u_s);
    sum_s     = u_ext + CENTER_S;
    pending_d = CNT_W'(sum_s);
    sat_d     = 1'b0;
    if (sum_s < MIN_S) begin
      pending_d = MIN_C;
      sat_d     = 1'b1;
    end else if (sum_s > MAX_S) begin
      pending_d = MAX_C;
      sat_d     = 1'b1;
    end
  end

  assign at_last = (cnt_q == LAST_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= CENTER_C;
      cmp_q     <= CENTER_C;
      pwm_q     <= 1'b0;
      tick_q    <= 1'b0;
      sat_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      if (load) begin
        pending_q <= pending_d;
        sat_q     <= sat_d;
      end
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          pwm_q  <= 1'b0;
          tick_q <= 1'b0;
          if (run) begin
            state_q  <= RUN;
            active_q <= 1'b1;
          end
        end
        RUN, STOPPING: begin
          pwm_q  <= (cnt_q < cmp_q);
          tick_q <= at_last;
          if (at_last) begin
            cnt_q <= '0;
            // A load on the boundary cycle bypasses pending straight into the next frame.
            cmp_q <= load ? pending_d : pending_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (state_q == RUN) begin
            if (!run) state_q <= STOPPING;
          end else if (at_last) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            cnt_q    <= '0;
          end else if (run) begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          pwm_q    <= 1'b0;
          tick_q   <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign pwm         = pwm_q;
  assign period_tick = tick_q;
  assign sat         = sat_q;
  assign active      = active_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with a 100-cycle frame and a 5..15 pulse window.
module tb_servo_pwm_gen;

  logic       clk;
  logic       reset;
  logic       run;
  logic       load;
  logic [7:0] control;
  logic       pwm;
  logic       period_tick;
  logic       sat;
  logic       active;

  int errors;
  int checks;

  servo_pwm_gen #(
    .Magnitud(7), .Decimal(0), .CNT_W(8), .PERIOD_CYCLES(100),
    .MIN_PULSE(5), .MAX_PULSE(15), .CENTER(10)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .load(load), .control(control),
    .pwm(pwm), .period_tick(period_tick), .sat(sat), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // From a tick cycle (cnt=0) walk one full frame; optionally strobe load at cnt=load_at.
  task automatic run_frame(input int load_at, input logic [7:0] load_val,
                           output int high, output bit tick_ok);
    high    = 0;
    tick_ok = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (pwm === 1'b1) high++;
      if ((i == 100) != (period_tick === 1'b1)) tick_ok = 1'b0;
      load = 1'b0;
      if (i == load_at) begin
        load    = 1'b1;
        control = load_val;
      end
    end
  endtask

  // From idle with run=1 applied, count negedges until the first tick (bounded).
  task automatic wait_first(output int cycles, output int high);
    cycles = 0;
    high   = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (pwm === 1'b1) high++;
    end while (period_tick !== 1'b1 && cycles < 300);
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; load = 1'b0; control = 8'd0;
    repeat (3) @(negedge clk);
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm got=%b exp=0", pwm); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", period_tick); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got=%b exp=0", sat); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active); end
  endtask

  task automatic test_center();
    int cyc, high; bit ok;
    reset = 1'b0; run = 1'b1;
    @(negedge clk);
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL center_active got=%b exp=1", active); end
    wait_first(cyc, high);
    checks++; if (cyc != 100) begin errors++; $display("FAIL center_first_tick got=%0d exp=100", cyc); end
    checks++; if (high != 10) begin errors++; $display("FAIL center_first_high got=%0d exp=10", high); end
    for (int f = 0; f < 2; f++) begin
      run_frame(-1, 8'd0, high, ok);
      checks++; if (high != 10) begin errors++; $display("FAIL center_high f=%0d got=%0d exp=10", f, high); end
      checks++; if (!ok) begin errors++; $display("FAIL center_tick f=%0d got=bad exp=tick@100", f); end
    end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL center_sat got=%b exp=0", sat); end
  endtask

  task automatic test_load();
    int high; bit ok;
    run_frame(40, 8'd3, high, ok);
    checks++; if (high != 10) begin errors++; $display("FAIL load_cur got=%0d exp=10", high); end
    run_frame(40, 8'hFE, high, ok);
    checks++; if (high != 13) begin errors++; $display("FAIL load_p3 got=%0d exp=13", high); end
    run_frame(-1, 8'd0, high, ok);
    checks++; if (high != 8) begin errors++; $display("FAIL load_m2 got=%0d exp=8", high); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL load_sat got=%b exp=0", sat); end
  endtask

  task automatic test_saturate();
    int high; bit ok;
    run_frame(40, 8'd100, high, ok);
    checks++; if (high != 8) begin errors++; $display("FAIL sat_prev got=%0d exp=8", high); end
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_hi_flag got=%b exp=1", sat); end
    run_frame(40, 8'h80, high, ok);
    checks++; if (high != 15) begin errors++; $display("FAIL sat_hi got=%0d exp=15", high); end
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_lo_flag got=%b exp=1", sat); end
    run_frame(40, 8'd0, high, ok);
    checks++; if (high != 5) begin errors++; $display("FAIL sat_lo got=%0d exp=5", high); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sat_clear got=%b exp=0", sat); end
    run_frame(-1, 8'd0, high, ok);
    checks++; if (high != 10) begin errors++; $display("FAIL sat_zero got=%0d exp=10", high); end
  endtask

  task automatic test_boundary_load();
    int high; bit ok;
    run_frame(99, 8'd4, high, ok);
    checks++; if (high != 10) begin errors++; $display("FAIL bnd_cur got=%0d exp=10", high); end
    run_frame(20, 8'd1, high, ok);
    checks++; if (high != 14) begin errors++; $display("FAIL bnd_next got=%0d exp=14", high); end
    run_frame(50, 8'd0, high, ok);
    checks++; if (high != 11) begin errors++; $display("FAIL bnd_replace got=%0d exp=11", high); end
    checks++; if (!ok) begin errors++; $display("FAIL bnd_tick got=bad exp=tick@100"); end
  endtask

  task automatic test_stop();
    int high, ticks, cyc; bit ok;
    high = 0; ok = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (pwm === 1'b1) high++;
      if ((i == 100) != (period_tick === 1'b1)) ok = 1'b0;
      if (i == 3) run = 1'b0;
      if (i == 50) begin
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL stop_active_mid got=%b exp=1", active); end
      end
    end
    checks++; if (high != 10) begin errors++; $display("FAIL stop_high got=%0d exp=10", high); end
    checks++; if (!ok) begin errors++; $display("FAIL stop_tick got=bad exp=tick@100"); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL stop_active_end got=%b exp=0", active); end
    high = 0; ticks = 0;
    repeat (150) begin
      @(negedge clk);
      if (pwm !== 1'b0) high++;
      if (period_tick !== 1'b0) ticks++;
    end
    checks++; if (high != 0) begin errors++; $display("FAIL idle_pwm got=%0d exp=0", high); end
    checks++; if (ticks != 0) begin errors++; $display("FAIL idle_ticks got=%0d exp=0", ticks); end
    run = 1'b1;
    wait_first(cyc, high);
    checks++; if (cyc != 101) begin errors++; $display("FAIL restart_tick got=%0d exp=101", cyc); end
    checks++; if (high != 10) begin errors++; $display("FAIL restart_high got=%0d exp=10", high); end
  endtask

  task automatic test_reset_mid();
    int cyc, high; bit ok;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (i == 2) begin load = 1'b1; control = 8'd100; end
    end
    checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL mid_pwm_pre got=%b exp=1", pwm); end
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL mid_sat_pre got=%b exp=1", sat); end
    #1 reset = 1'b1;
    #1;
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL mid_pwm got=%b exp=0", pwm); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL mid_sat got=%b exp=0", sat); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL mid_active got=%b exp=0", active); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL mid_tick got=%b exp=0", period_tick); end
    @(negedge clk);
    reset = 1'b0;
    wait_first(cyc, high);
    checks++; if (cyc != 101) begin errors++; $display("FAIL post_tick got=%0d exp=101", cyc); end
    checks++; if (high != 10) begin errors++; $display("FAIL post_high got=%0d exp=10", high); end
    run_frame(-1, 8'd0, high, ok);
    checks++; if (high != 10) begin errors++; $display("FAIL post_pending got=%0d exp=10", high); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_center();
    test_load();
    test_saturate();
    test_boundary_load();
    test_stop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
